// File: rtl/host_cmd_arbiter.sv
// Round-robin share of the root host port between two masters.
// Optional read timeout enabled by defining READ_TIMEOUT_EN.
module host_cmd_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int RDATA_W     = 28,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            cmd_valid,
  output logic [1:0]            cmd_ready,
  input  logic [1:0]            cmd_we,
  input  logic [2*ADDR_W-1:0]   cmd_addr,
  input  logic [2*DATA_W-1:0]   cmd_wdata,
  output logic [1:0]            rsp_valid,
  output logic [RDATA_W-1:0]    rsp_data,
  output logic                  rsp_err,
  output logic [1:0]            done,
  output logic                  write_en,
  output logic [ADDR_W-1:0]     write_addr,
  output logic [DATA_W-1:0]     write_data,
  input  logic                  write_rdy,
  output logic                  read_en,
  output logic [ADDR_W-1:0]     read_addr,
  input  logic                  read_rdy,
  output logic                  read_data_rdy,
  input  logic                  read_data_vld,
  input  logic [RDATA_W-1:0]    read_data,
  input  logic                  interrupt
);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    COMP_BUSY
  } state_t;

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  state_t               r_state;
  state_t               w_next;
  logic                 r_rr;
  logic                 r_owner;
  logic [11:0]          r_rd_addr;
  logic [1:0]           r_rsp_valid;
  logic [RDATA_W-1:0]   r_rsp_data;
  logic                 r_rsp_err;
  logic [1:0]           r_done;

  logic [1:0]           w_elig;
  logic                 w_gnt;
  logic                 w_g;
  logic                 w_we;
  logic [ADDR_W-1:0]    w_addr;
  logic [DATA_W-1:0]    w_wdata;
  logic                 w_match;
  logic                 w_tmo;
  logic                 w_irq;

  always_comb begin
    w_elig[0] = cmd_valid[0] && (cmd_we[0] ? write_rdy : read_rdy);
    w_elig[1] = cmd_valid[1] && (cmd_we[1] ? write_rdy : read_rdy);
    w_gnt     = (r_state == IDLE) && !rst && (|w_elig);
    w_g       = (&w_elig) ? r_rr : w_elig[1];
    w_we      = w_g ? cmd_we[1] : cmd_we[0];
    w_addr    = w_g ? cmd_addr[ADDR_W +: ADDR_W]
                    : cmd_addr[0 +: ADDR_W];
    w_wdata   = w_g ? cmd_wdata[DATA_W +: DATA_W]
                    : cmd_wdata[0 +: DATA_W];
  end

  always_comb begin
    cmd_ready  = '0;
    write_en   = 1'b0;
    write_addr = '0;
    write_data = '0;
    read_en    = 1'b0;
    read_addr  = '0;
    if (w_gnt) begin
      cmd_ready[w_g] = 1'b1;
      if (w_we) begin
        write_en   = 1'b1;
        write_addr = w_addr;
        write_data = w_wdata;
      end else begin
        read_en    = 1'b1;
        read_addr  = w_addr;
      end
    end
  end

  assign read_data_rdy = (r_state == RD_WAIT) && !rst;
  assign w_match = read_data_rdy && read_data_vld &&
                   (read_data[RDATA_W-1 -: 12] == r_rd_addr);
  assign w_irq   = (r_state == COMP_BUSY) && interrupt;

`ifdef READ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (read_en) begin
      r_cnt <= '0;
    end else if (r_state == RD_WAIT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A matching response in the same cycle beats the timeout
  assign w_tmo = read_data_rdy && !w_match && (r_cnt == CNT_MAX);
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_gnt) begin
          if (!w_we)
            w_next = RD_WAIT;
          else if (&w_addr)
            w_next = COMP_BUSY;
        end
      end
      RD_WAIT: begin
        if (w_match || w_tmo)
          w_next = IDLE;
      end
      COMP_BUSY: begin
        if (interrupt)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr      <= 1'b0;
      r_owner   <= 1'b0;
      r_rd_addr <= '0;
    end else if (w_gnt) begin
      r_rr    <= ~w_g;
      r_owner <= w_g;
      if (!w_we)
        r_rd_addr <= w_addr[11:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_done      <= '0;
    end else begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_done      <= '0;
      if (w_match) begin
        r_rsp_valid[r_owner] <= 1'b1;
        r_rsp_data           <= read_data;
      end else if (w_tmo) begin
        r_rsp_valid[r_owner] <= 1'b1;
        r_rsp_err            <= 1'b1;
      end
      if (w_irq)
        r_done[r_owner] <= 1'b1;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign done      = r_done;

endmodule

// File: tb/tb_host_cmd_arbiter.sv
// Directed bench for host_cmd_arbiter.
// Define READ_TIMEOUT_EN to also exercise the read timeout.
module tb_host_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cmd_valid;
  logic [1:0]  cmd_ready;
  logic [1:0]  cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [1:0]  rsp_valid;
  logic [27:0] rsp_data;
  logic        rsp_err;
  logic [1:0]  done;
  logic        write_en;
  logic [15:0] write_addr;
  logic [15:0] write_data;
  logic        write_rdy;
  logic        read_en;
  logic [15:0] read_addr;
  logic        read_rdy;
  logic        read_data_rdy;
  logic        read_data_vld;
  logic [27:0] read_data;
  logic        interrupt;

  int total = 0;
  int bad   = 0;

  host_cmd_arbiter #(
    .ADDR_W(16), .DATA_W(16), .RDATA_W(28), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .done(done),
    .write_en(write_en), .write_addr(write_addr),
    .write_data(write_data), .write_rdy(write_rdy),
    .read_en(read_en), .read_addr(read_addr), .read_rdy(read_rdy),
    .read_data_rdy(read_data_rdy), .read_data_vld(read_data_vld),
    .read_data(read_data), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 2'b11; cmd_we = 2'b11;
    cmd_addr = 32'h0020_0010; cmd_wdata = 32'h5555_AAAA;
    write_rdy = 1'b1; read_rdy = 1'b1;
    read_data_vld = 1'b0; read_data = '0; interrupt = 1'b0;
    #1;
    chk("rst_ready", cmd_ready, 2'b00);
    chk("rst_wen", write_en, 1'b0);
    nxt(); nxt();
    cmd_valid = 2'b00;
    rst = 1'b0;
    #1;
    chk("idle_ready", cmd_ready, 2'b00);
    chk("idle_rsp", rsp_valid, 2'b00);
    chk("idle_done", done, 2'b00);
    chk("idle_rdrdy", read_data_rdy, 1'b0);

    // 1: simultaneous writes, m0 then m1
    cmd_valid = 2'b11;
    #1;
    chk("t1_rdy0", cmd_ready, 2'b01);
    chk("t1_wen0", write_en, 1'b1);
    chk("t1_waddr0", write_addr, 16'h0010);
    chk("t1_wdata0", write_data, 16'hAAAA);
    nxt();
    cmd_valid = 2'b10;
    #1;
    chk("t1_rdy1", cmd_ready, 2'b10);
    chk("t1_waddr1", write_addr, 16'h0020);
    chk("t1_wdata1", write_data, 16'h5555);
    nxt();
    cmd_valid = 2'b00;
    #1;
    chk("t1_quiet", write_en, 1'b0);

    // 2: m1 read, m0 write blocked while waiting
    nxt();
    cmd_valid = 2'b10; cmd_we = 2'b00;
    cmd_addr = 32'h0123_0000;
    #1;
    chk("t2_rdy", cmd_ready, 2'b10);
    chk("t2_ren", read_en, 1'b1);
    chk("t2_raddr", read_addr, 16'h0123);
    nxt();
    cmd_valid = 2'b01; cmd_we = 2'b01;
    cmd_addr = 32'h0000_0050; cmd_wdata = 32'h0000_1111;
    #1;
    chk("t2_rdrdy", read_data_rdy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("t2_nogrant", cmd_ready, 2'b00);
      nxt();
      #1;
    end
    read_data_vld = 1'b1; read_data = 28'h123ABCD;
    nxt();
    read_data_vld = 1'b0;
    #1;
    chk("t2_rspv", rsp_valid, 2'b10);
    chk("t2_rspd", rsp_data, 28'h123ABCD);
    chk("t2_rsperr", rsp_err, 1'b0);
    chk("t2_wgrant", cmd_ready, 2'b01);
    chk("t2_waddr", write_addr, 16'h0050);
    nxt();
    cmd_valid = 2'b00;
    #1;
    chk("t2_rsp_off", rsp_valid, 2'b00);
    chk("t2_rspd_off", rsp_data, 28'h0);

    // 3: stale data discarded
    cmd_valid = 2'b01; cmd_we = 2'b00;
    cmd_addr = 32'h0000_0005;
    #1;
    chk("t3_raddr", read_addr, 16'h0005);
    nxt();
    cmd_valid = 2'b00;
    read_data_vld = 1'b1; read_data = 28'h0990000;
    nxt();
    #1;
    chk("t3_stale", rsp_valid, 2'b00);
    chk("t3_wait", read_data_rdy, 1'b1);
    read_data = 28'h0051234;
    nxt();
    read_data_vld = 1'b0;
    #1;
    chk("t3_rspv", rsp_valid, 2'b01);
    chk("t3_rspd", rsp_data, 28'h0051234);

    // 4: start computation locks bus until interrupt
    nxt();
    cmd_valid = 2'b01; cmd_we = 2'b01;
    cmd_addr = 32'h0000_FFFF;
    #1;
    chk("t4_start", cmd_ready, 2'b01);
    nxt();
    cmd_valid = 2'b10; cmd_we = 2'b10;
    cmd_addr = 32'h0077_0000; cmd_wdata = 32'h7777_0000;
    for (int i = 0; i < 100; i++) begin
      #1;
      chk("t4_busy", cmd_ready, 2'b00);
      nxt();
    end
    interrupt = 1'b1;
    nxt();
    interrupt = 1'b0;
    #1;
    chk("t4_done", done, 2'b01);
    chk("t4_m1", cmd_ready, 2'b10);
    chk("t4_m1addr", write_addr, 16'h0077);
    nxt();
    cmd_valid = 2'b00;
    #1;
    chk("t4_done_off", done, 2'b00);

    // 5: write_rdy low, read still granted
    write_rdy = 1'b0;
    cmd_valid = 2'b11; cmd_we = 2'b01;
    cmd_addr = 32'h0044_0030;
    #1;
    chk("t5_rdy", cmd_ready, 2'b10);
    chk("t5_ren", read_en, 1'b1);
    chk("t5_wen", write_en, 1'b0);
    chk("t5_raddr", read_addr, 16'h0044);
    nxt();
    cmd_valid = 2'b01;
    read_data_vld = 1'b1; read_data = 28'h0440042;
    nxt();
    read_data_vld = 1'b0;
    #1;
    chk("t5_rspv", rsp_valid, 2'b10);
    chk("t5_rspd", rsp_data, 28'h0440042);
    chk("t5_wblk", cmd_ready, 2'b00);
    write_rdy = 1'b1;
    #1;
    chk("t5_wgo", cmd_ready, 2'b01);
    nxt();
    cmd_valid = 2'b00;

    // interrupt in IDLE ignored
    interrupt = 1'b1;
    nxt();
    interrupt = 1'b0;
    #1;
    chk("irq_idle", done, 2'b00);

    // reset mid-read
    cmd_valid = 2'b01; cmd_we = 2'b00;
    cmd_addr = 32'h0000_0007;
    nxt();
    cmd_valid = 2'b00;
    #1;
    chk("mr_wait", read_data_rdy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mr_rst", read_data_rdy, 1'b0);
    nxt();
    rst = 1'b0;
    read_data_vld = 1'b1; read_data = 28'h0070000;
    nxt();
    read_data_vld = 1'b0;
    #1;
    chk("mr_norsp", rsp_valid, 2'b00);
    cmd_valid = 2'b11; cmd_we = 2'b11;
    cmd_addr = 32'h0002_0001;
    #1;
    chk("mr_rr0", cmd_ready, 2'b01);
    nxt();
    cmd_valid = 2'b00;

`ifdef READ_TIMEOUT_EN
    // 6: timeout after 16 RD_WAIT cycles
    cmd_valid = 2'b01; cmd_we = 2'b00;
    cmd_addr = 32'h0000_0009;
    nxt();
    cmd_valid = 2'b00;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("t6_pending", rsp_valid, 2'b00);
      nxt();
    end
    #1;
    chk("t6_rspv", rsp_valid, 2'b01);
    chk("t6_err", rsp_err, 1'b1);
    chk("t6_rspd", rsp_data, 28'h0);
    nxt();
    #1;
    chk("t6_idle", read_data_rdy, 1'b0);
    chk("t6_off", rsp_valid, 2'b00);
    cmd_valid = 2'b10; cmd_we = 2'b00;
    cmd_addr = 32'h000A_0000;
    nxt();
    cmd_valid = 2'b00;
    read_data_vld = 1'b1; read_data = 28'h0091111;
    nxt();
    read_data = 28'h00A2222;
    #1;
    chk("t6_late", rsp_valid, 2'b00);
    nxt();
    read_data_vld = 1'b0;
    #1;
    chk("t6_rsp2", rsp_valid, 2'b10);
    chk("t6_rsp2d", rsp_data, 28'h00A2222);
    chk("t6_rsp2e", rsp_err, 1'b0);
`endif

    nxt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
